// File: rtl/led_matrix_scanner_pkg.sv
// Shared definitions for the LED matrix scanner.
// Contents:
//   scan_state_t              - scanner state encoding (ST_BLANK=0, ST_ON=1)
//   MATRIX_ROWS / MATRIX_COLS - matrix geometry (8x8)
//   ROW_IDX_W                 - width of a row index
//   apply_polarity()          - converts an active-high pattern to pin level
package led_matrix_scanner_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int ROW_IDX_W   = $clog2(MATRIX_ROWS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // Active-high pattern in, pin-level pattern out.
  function automatic logic [MATRIX_COLS-1:0] apply_polarity(
    input logic [MATRIX_COLS-1:0] pattern,
    input logic                   active_low
  );
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Bus between the CPU peripheral side and the LED matrix scanner.
// Signals:
//   writeEnable / writeRow / writeData - back-buffer row write
//   swapRequest                        - one-cycle front/back swap request
//   swapPending                        - swap accepted, waiting for frame end
//   frameStart                         - pulse on first blank cycle of row 0
//   ledMatrixRow / ledMatrixColumn     - matrix pin drive
// Modports:
//   master - CPU/bench side, drives writes and swap requests
//   slave  - scanner side
interface led_matrix_scanner_if;
  import led_matrix_scanner_pkg::*;

  logic                   writeEnable;
  logic [ROW_IDX_W-1:0]   writeRow;
  logic [MATRIX_COLS-1:0] writeData;
  logic                   swapRequest;
  logic                   swapPending;
  logic                   frameStart;
  logic [MATRIX_ROWS-1:0] ledMatrixRow;
  logic [MATRIX_COLS-1:0] ledMatrixColumn;

  modport master (
    output writeEnable, writeRow, writeData, swapRequest,
    input  swapPending, frameStart, ledMatrixRow, ledMatrixColumn
  );

  modport slave (
    input  writeEnable, writeRow, writeData, swapRequest,
    output swapPending, frameStart, ledMatrixRow, ledMatrixColumn
  );

endinterface

// File: rtl/matrix_framebuffer.sv
// Double-buffered 8x8 pixel store: two banks of eight 8-bit rows.
// Ports:
//   clk, rst       - clock, asynchronous active-high clear of both banks
//   i_writeEnable  - store i_writeData into bank ~i_frontSel, row i_writeRow
//   i_writeRow     - target row of the write
//   i_writeData    - pixel bits, bit i = column i
//   i_frontSel     - bank currently displayed; writes go to the other bank
//   i_readBank     - bank read by the combinational read port
//   i_readRow      - row read by the combinational read port
//   o_readData     - r_bank[i_readBank][i_readRow]
module matrix_framebuffer
  import led_matrix_scanner_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_writeEnable,
  input  logic [ROW_IDX_W-1:0]   i_writeRow,
  input  logic [MATRIX_COLS-1:0] i_writeData,
  input  logic                   i_frontSel,
  input  logic                   i_readBank,
  input  logic [ROW_IDX_W-1:0]   i_readRow,
  output logic [MATRIX_COLS-1:0] o_readData
);

  logic [MATRIX_COLS-1:0] r_bank [0:1][0:MATRIX_ROWS-1];

  // Only the back bank is ever written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < MATRIX_ROWS; r++) begin
          r_bank[b][r] <= '0;
        end
      end
    end else if (i_writeEnable) begin
      r_bank[~i_frontSel][i_writeRow] <= i_writeData;
    end
  end

  assign o_readData = r_bank[i_readBank][i_readRow];

endmodule

// File: rtl/led_matrix_scanner.sv
// Multiplexed scan controller for an 8x8 LED matrix with a double-buffered
// framebuffer. Each row gets BLANK_TICKS cycles of all-off followed by
// ROW_TICKS cycles lit; a frame is 8 such slots. Swap requests are committed
// at the frame boundary so the displayed image never tears.
// Parameters:
//   ROW_TICKS      - cycles each row is lit (>= 1)
//   BLANK_TICKS    - cycles of all-off before each row (>= 1)
//   ROW_ACTIVE_LOW - 1: selected row pin driven 0, others 1
//   COL_ACTIVE_LOW - 1: lit column pin driven 0
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - led_matrix_scanner_if.slave (writes, swap handshake, pins)
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int ROW_TICKS      = 1000,
  parameter int BLANK_TICKS    = 16,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 1
)(
  input  logic                 clk,
  input  logic                 rst,
  led_matrix_scanner_if.slave  bus
);

  localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  localparam logic ROW_AL = (ROW_ACTIVE_LOW != 0);
  localparam logic COL_AL = (COL_ACTIVE_LOW != 0);

  localparam logic [MATRIX_ROWS-1:0] ROW_OFF = apply_polarity('0, ROW_AL);
  localparam logic [MATRIX_COLS-1:0] COL_OFF = apply_polarity('0, COL_AL);

  // r_state/r_tick/r_row describe the scan position whose pin levels are
  // loaded into the output registers at the next clock edge.
  scan_state_t            r_state;
  logic [CNT_W-1:0]       r_tick;
  logic [ROW_IDX_W-1:0]   r_row;
  logic                   r_frontSel;
  logic                   r_swapPending;
  logic                   r_frameStart;
  logic [MATRIX_COLS-1:0] r_colLatch;
  logic [MATRIX_ROWS-1:0] r_rowOut;
  logic [MATRIX_COLS-1:0] r_colOut;

  logic                   w_frameBoundary;
  logic                   w_swap;
  logic                   w_frontSelNext;
  logic                   w_blankLast;
  logic                   w_rowLast;
  logic [MATRIX_ROWS-1:0] w_rowOneHot;
  logic [MATRIX_COLS-1:0] w_frontRowData;
  logic [MATRIX_COLS-1:0] w_latchData;

  assign w_frameBoundary = (r_state == ST_BLANK) && (r_tick == '0) && (r_row == '0);
  // A request arriving in the boundary cycle is folded into that swap.
  assign w_swap          = w_frameBoundary && (r_swapPending || bus.swapRequest);
  assign w_frontSelNext  = w_swap ? ~r_frontSel : r_frontSel;
  assign w_blankLast     = (r_tick == BLANK_LAST);
  assign w_rowLast       = (r_tick == ROW_LAST);
  assign w_rowOneHot     = MATRIX_ROWS'(1) << r_row;

  matrix_framebuffer u_framebuffer (
    .clk           (clk),
    .rst           (rst),
    .i_writeEnable (bus.writeEnable),
    .i_writeRow    (bus.writeRow),
    .i_writeData   (bus.writeData),
    .i_frontSel    (r_frontSel),
    .i_readBank    (w_frontSelNext),
    .i_readRow     (r_row),
    .o_readData    (w_frontRowData)
  );

  // With BLANK_TICKS == 1 the row-0 latch coincides with the swap edge; a
  // write to that row in the same cycle lands in the new front bank, so
  // forward it instead of the stale stored value.
  assign w_latchData = (w_swap && bus.writeEnable && (bus.writeRow == r_row))
                       ? bus.writeData : w_frontRowData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BLANK;
      r_tick        <= '0;
      r_row         <= '0;
      r_frontSel    <= 1'b0;
      r_swapPending <= 1'b0;
      r_frameStart  <= 1'b0;
      r_colLatch    <= '0;
      r_rowOut      <= ROW_OFF;
      r_colOut      <= COL_OFF;
    end else begin
      r_frameStart <= w_frameBoundary;

      if (w_swap) begin
        r_frontSel    <= ~r_frontSel;
        r_swapPending <= 1'b0;
      end else if (bus.swapRequest) begin
        r_swapPending <= 1'b1;
      end

      case (r_state)
        ST_BLANK: begin
          r_rowOut <= ROW_OFF;
          r_colOut <= COL_OFF;
          if (w_blankLast) begin
            r_state    <= ST_ON;
            r_tick     <= '0;
            r_colLatch <= w_latchData;
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
        ST_ON: begin
          r_rowOut <= apply_polarity(w_rowOneHot, ROW_AL);
          r_colOut <= apply_polarity(r_colLatch, COL_AL);
          if (w_rowLast) begin
            r_state <= ST_BLANK;
            r_tick  <= '0;
            r_row   <= r_row + ROW_IDX_W'(1);
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign bus.swapPending     = r_swapPending;
  assign bus.frameStart      = r_frameStart;
  assign bus.ledMatrixRow    = r_rowOut;
  assign bus.ledMatrixColumn = r_colOut;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (ROW_TICKS=4, BLANK_TICKS=2,
// rows active-high, columns active-low). Cycle n is the interval after the
// n-th rising edge following reset release (edge 0 = first edge).
module tb_led_matrix_scanner;

  localparam int ROW_T   = 4;
  localparam int BLANK_T = 2;
  localparam int SLOT    = ROW_T + BLANK_T;
  localparam int FRAME   = 8 * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_matrix_scanner_if bus();

  led_matrix_scanner #(
    .ROW_TICKS      (ROW_T),
    .BLANK_TICKS    (BLANK_T),
    .ROW_ACTIVE_LOW (0),
    .COL_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;

  // Reference model: two banks, which one is shown, and the pending flag.
  logic [7:0] m_bank [0:1][0:7];
  logic       m_fsel;
  logic       m_pend;

  function automatic logic [17:0] obs();
    return {bus.frameStart, bus.swapPending, bus.ledMatrixRow, bus.ledMatrixColumn};
  endfunction

  // Expected {frameStart, swapPending, row, column} for the current cycle,
  // from the slot arithmetic: row r owns cycles r*SLOT .. r*SLOT+SLOT-1 of
  // each frame, the first BLANK_T of which are dark.
  function automatic logic [17:0] expv();
    int p, r, w;
    logic [7:0] er, ec;
    p = cyc % FRAME;
    r = p / SLOT;
    w = p % SLOT;
    if (w >= BLANK_T) begin
      er = 8'(1 << r);
      ec = ~m_bank[m_fsel][r];
    end else begin
      er = 8'h00;
      ec = 8'hFF;
    end
    return {(p == 0), m_pend, er, ec};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        m_bank[b][r] = 8'h00;
    m_fsel = 1'b0;
    m_pend = 1'b0;
    cyc    = -1;
  endtask

  task automatic idle_inputs();
    bus.writeEnable = 1'b0;
    bus.writeRow    = 3'd0;
    bus.writeData   = 8'h00;
    bus.swapRequest = 1'b0;
  endtask

  // Drive inputs for the current cycle, take one edge, update the model.
  task automatic tick(input logic we, input logic [2:0] wr,
                      input logic [7:0] wd, input logic sr);
    bus.writeEnable = we;
    bus.writeRow    = wr;
    bus.writeData   = wd;
    bus.swapRequest = sr;
    @(posedge clk);
    cyc++;
    if (we) m_bank[!m_fsel][wr] = wd;
    if ((cyc % FRAME == 0) && (m_pend || sr)) begin
      m_fsel = !m_fsel;
      m_pend = 1'b0;
    end else if (sr) begin
      m_pend = 1'b1;
    end
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL reset_immediate got=%h want=%h", obs(), {1'b0, 1'b0, 8'h00, 8'hFF});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL reset_held got=%h want=%h", obs(), {1'b0, 1'b0, 8'h00, 8'hFF});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle_scan();
    apply_reset();
    repeat (3 * FRAME + 1) begin
      tick(1'b0, 3'd0, 8'h00, 1'b0);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL idle_scan cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (cyc == 0 || cyc == 48 || cyc == 96) begin
        checks++;
        if (bus.frameStart !== 1'b1) begin
          failures++;
          $display("FAIL idle_frameStart cyc=%0d got=%b want=1", cyc, bus.frameStart);
        end
      end
      if (cyc >= 2 && cyc <= 5) begin
        checks++;
        if (bus.ledMatrixRow !== 8'h01) begin
          failures++;
          $display("FAIL idle_row0 cyc=%0d got=%h want=01", cyc, bus.ledMatrixRow);
        end
      end
      if (cyc >= 44 && cyc <= 47) begin
        checks++;
        if (bus.ledMatrixRow !== 8'h80) begin
          failures++;
          $display("FAIL idle_row7 cyc=%0d got=%h want=80", cyc, bus.ledMatrixRow);
        end
      end
    end
  endtask

  task automatic test_swap();
    apply_reset();
    while (cyc < 2 * FRAME) begin
      tick(cyc == 3, 3'd3, 8'hA5, cyc == 10);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL swap_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (cyc >= 11 && cyc <= 48) begin
        checks++;
        if (bus.swapPending !== (cyc <= 47)) begin
          failures++;
          $display("FAIL swap_pending cyc=%0d got=%b want=%b", cyc, bus.swapPending, cyc <= 47);
        end
      end
      if (cyc >= 48 && cyc < 96) begin
        checks++;
        if (bus.ledMatrixColumn !== ((bus.ledMatrixRow == 8'h08) ? 8'h5A : 8'hFF)) begin
          failures++;
          $display("FAIL swap_column cyc=%0d row=%h got=%h", cyc, bus.ledMatrixRow, bus.ledMatrixColumn);
        end
      end
    end
  endtask

  task automatic test_write_no_swap();
    logic [7:0] d;
    apply_reset();
    d = 8'($urandom_range(1, 255));
    while (cyc < 3 * FRAME) begin
      tick(cyc == 7, 3'd5, d, 1'b0);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL noswap_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      checks++;
      if (bus.ledMatrixColumn !== 8'hFF) begin
        failures++;
        $display("FAIL noswap_column cyc=%0d got=%h want=ff", cyc, bus.ledMatrixColumn);
      end
    end
  endtask

  task automatic test_swap_at_boundary();
    apply_reset();
    while (cyc < 3 * FRAME + 10) begin
      tick(cyc == 47, 3'd0, 8'h0F, cyc == 47);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL boundary_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (cyc >= 48) begin
        checks++;
        if (bus.swapPending !== 1'b0) begin
          failures++;
          $display("FAIL boundary_pending cyc=%0d got=%b want=0", cyc, bus.swapPending);
        end
      end
      if ((cyc >= 50 && cyc <= 53) || (cyc >= 98 && cyc <= 101)) begin
        checks++;
        if (bus.ledMatrixColumn !== 8'hF0) begin
          failures++;
          $display("FAIL boundary_column cyc=%0d got=%h want=f0", cyc, bus.ledMatrixColumn);
        end
      end
    end
  endtask

  task automatic test_back_to_back_requests();
    apply_reset();
    while (cyc < 2 * FRAME + 14) begin
      tick(cyc == 1, 3'd1, 8'h3C, cyc == 5 || cyc == 20);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL double_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (cyc == 47 || cyc == 48) begin
        checks++;
        if (bus.swapPending !== (cyc == 47)) begin
          failures++;
          $display("FAIL double_pending cyc=%0d got=%b want=%b", cyc, bus.swapPending, cyc == 47);
        end
      end
      if ((cyc >= 56 && cyc <= 59) || (cyc >= 104 && cyc <= 107)) begin
        checks++;
        if (bus.ledMatrixColumn !== 8'hC3) begin
          failures++;
          $display("FAIL double_column cyc=%0d got=%h want=c3", cyc, bus.ledMatrixColumn);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    while (cyc < FRAME + 20) begin
      tick(cyc != 47, 3'($urandom_range(0, 7)), 8'($urandom_range(1, 255)), cyc == 2);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL midreset_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (bus.ledMatrixRow !== 8'h08) begin
      failures++;
      $display("FAIL midreset_lit got=%h want=08", bus.ledMatrixRow);
    end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL midreset_async got=%h want=%h", obs(), {1'b0, 1'b0, 8'h00, 8'hFF});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    while (cyc < 2 * FRAME + 2) begin
      tick(1'b0, 3'd0, 8'h00, cyc == 3);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL postreset_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      checks++;
      if (bus.ledMatrixColumn !== 8'hFF) begin
        failures++;
        $display("FAIL postreset_cleared cyc=%0d got=%h want=ff", cyc, bus.ledMatrixColumn);
      end
      if (cyc == 0) begin
        checks++;
        if (bus.frameStart !== 1'b1) begin
          failures++;
          $display("FAIL postreset_frameStart got=%b want=1", bus.frameStart);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    repeat (5 * FRAME) begin
      tick($urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 29) == 0);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_idle_scan();
    test_swap();
    test_write_no_swap();
    test_swap_at_boundary();
    test_back_to_back_requests();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
